// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: CA word layout plus the responder's state enum and CR0 layout.
package hyperbus_pkg;

  typedef struct packed {
    logic        rw_n;           // 1 = read
    logic        address_space;  // 1 = register space
    logic        burst_type;     // 1 = linear, 0 = wrapped
    logic [28:0] addr_upper;
    logic [12:0] reserved;
    logic [2:0]  addr_lower;
  } hyper_phy_ca_t;

  typedef enum logic [2:0] {
    RESP_IDLE,
    RESP_RECV_CA,
    RESP_WAIT_LAT,
    RESP_READ,
    RESP_WRITE
  } hyper_resp_state_t;

  typedef struct packed {
    logic [7:0] id;
    logic [3:0] latency;  // 0 selects the default latency
    logic       add_lat;
    logic [2:0] rsvd;
  } hyper_resp_cr0_t;

  localparam int          CaWords     = 3;
  localparam logic [15:0] Cr0WordAddr = 16'h0800;

endpackage

// File: rtl/hyperbus_resp_addr_gen.sv
// Burst word-address generator: loads the CA address, then steps linearly or
// wraps inside an aligned WrapWords-word window.
module hyperbus_resp_addr_gen #(
  parameter int AddrWidth = 16,
  parameter int WrapWords = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] load_addr_i,
  input  logic                 linear_i,
  input  logic                 inc_i,
  output logic [AddrWidth-1:0] addr_o
);

  localparam int WrapBits = $clog2(WrapWords);

  logic [AddrWidth-1:0] addr_reg, addr_next, addr_plus1, addr_wrapped;
  logic                 linear_reg, linear_next;

  assign addr_plus1 = addr_reg + AddrWidth'(1);

  // Wrapped mode takes only the low bits from the incremented value.
  genvar gi;
  generate
    for (gi = 0; gi < AddrWidth; gi++) begin : g_wrap
      if (gi < WrapBits) begin : g_low
        assign addr_wrapped[gi] = addr_plus1[gi];
      end else begin : g_high
        assign addr_wrapped[gi] = addr_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    addr_next   = addr_reg;
    linear_next = linear_reg;
    if (load_i) begin
      addr_next   = load_addr_i;
      linear_next = linear_i;
    end else if (inc_i) begin
      addr_next = linear_reg ? addr_plus1 : addr_wrapped;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_reg   <= '0;
      linear_reg <= 1'b0;
    end else begin
      addr_reg   <= addr_next;
      linear_reg <= linear_next;
    end
  end

  assign addr_o = addr_reg;

endmodule

// File: rtl/hyperbus_phy_responder.sv
// HyperBus responder PHY (word level): CA capture, latency wait, SRAM-backed bursts.
// Define HYPERBUS_RESP_REGS_EN to implement CR0 in register space.
module hyperbus_phy_responder
  import hyperbus_pkg::*;
#(
  parameter int   AddrWidth  = 16,
  parameter int   WrapWords  = 16,
  parameter int   LatDefault = 6,
  parameter logic AddLat     = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cs_ni,
  input  logic [15:0]          dq_i,
  input  logic [1:0]           rwds_i,
  output logic [15:0]          dq_o,
  output logic                 dq_oe_o,
  output logic                 rwds_o,
  output logic                 rwds_oe_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [15:0]          mem_wdata_o,
  output logic [1:0]           mem_be_o,
  input  logic [15:0]          mem_rdata_i
);

  localparam logic [3:0] LatDefaultW = 4'(LatDefault);

  hyper_resp_state_t    state_reg, state_next;
  logic                 cs_prev_reg;
  logic [1:0]           ca_cnt_reg, ca_cnt_next;
  logic [31:0]          ca_shift_reg, ca_shift_next;
  logic [4:0]           lat_cnt_reg, lat_cnt_next;
  logic                 is_read_reg, is_read_next;
  logic                 is_reg_reg, is_reg_next;
  logic                 addr_load, addr_inc;
  logic [AddrWidth-1:0] addr_cur;
  hyper_phy_ca_t        ca;
  logic [31:0]          ca_addr_full;
  logic [AddrWidth-1:0] load_addr;
  logic [3:0]           eff_lat;
  logic                 eff_addlat;
  logic [4:0]           lat_total;
  logic [15:0]          reg_rdata;
  logic                 unused_bits;

  // The 3rd CA word is decoded straight off dq_i, not after it is shifted in.
  assign ca           = hyper_phy_ca_t'({ca_shift_reg, dq_i});
  assign ca_addr_full = {ca.addr_upper, ca.addr_lower};
  assign load_addr    = ca_addr_full[AddrWidth-1:0];
  assign lat_total    = eff_addlat ? {eff_lat, 1'b0} : {1'b0, eff_lat};
  assign unused_bits  = ^{ca.reserved, ca_addr_full};

`ifdef HYPERBUS_RESP_REGS_EN
  hyper_resp_cr0_t cr0_reg, cr0_next;
  logic            reg_hit_reg, reg_hit_next;
  logic            reg_done_reg, reg_done_next;

  assign eff_lat    = (cr0_reg.latency == 4'd0) ? LatDefaultW : cr0_reg.latency;
  assign eff_addlat = cr0_reg.add_lat;
  assign reg_rdata  = reg_hit_reg ? 16'(cr0_reg) : 16'h0000;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cr0_reg      <= hyper_resp_cr0_t'({8'h8F, LatDefaultW, AddLat, 3'b111});
      reg_hit_reg  <= 1'b0;
      reg_done_reg <= 1'b0;
    end else begin
      cr0_reg      <= cr0_next;
      reg_hit_reg  <= reg_hit_next;
      reg_done_reg <= reg_done_next;
    end
  end
`else
  assign eff_lat    = LatDefaultW;
  assign eff_addlat = AddLat;
  assign reg_rdata  = 16'h0000;
`endif

  always_comb begin
    state_next    = state_reg;
    ca_cnt_next   = ca_cnt_reg;
    ca_shift_next = ca_shift_reg;
    lat_cnt_next  = lat_cnt_reg;
    is_read_next  = is_read_reg;
    is_reg_next   = is_reg_reg;
    addr_load     = 1'b0;
    addr_inc      = 1'b0;
    dq_o          = 16'h0000;
    dq_oe_o       = 1'b0;
    rwds_o        = 1'b0;
    rwds_oe_o     = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_wdata_o   = 16'h0000;
    mem_be_o      = 2'b00;
`ifdef HYPERBUS_RESP_REGS_EN
    cr0_next      = cr0_reg;
    reg_hit_next  = reg_hit_reg;
    reg_done_next = reg_done_reg;
`endif
    if (cs_ni) begin
      state_next  = RESP_IDLE;
      ca_cnt_next = 2'd0;
    end else begin
      case (state_reg)
        RESP_IDLE: begin
          if (cs_prev_reg) begin
            state_next  = RESP_RECV_CA;
            ca_cnt_next = 2'd0;
          end
        end
        RESP_RECV_CA: begin
          rwds_oe_o     = 1'b1;
          rwds_o        = eff_addlat;
          ca_shift_next = {ca_shift_reg[15:0], dq_i};
          ca_cnt_next   = ca_cnt_reg + 2'd1;
          if (ca_cnt_reg == 2'(CaWords - 1)) begin
            addr_load    = 1'b1;
            is_read_next = ca.rw_n;
            is_reg_next  = ca.address_space;
`ifdef HYPERBUS_RESP_REGS_EN
            reg_hit_next  = (load_addr == AddrWidth'(Cr0WordAddr));
            reg_done_next = 1'b0;
`endif
            if (!ca.rw_n && ca.address_space) begin
              state_next = RESP_WRITE;
            end else begin
              state_next   = RESP_WAIT_LAT;
              lat_cnt_next = lat_total - 5'd1;
            end
          end
        end
        RESP_WAIT_LAT: begin
          if (lat_cnt_reg == 5'd0) begin
            state_next = is_read_reg ? RESP_READ : RESP_WRITE;
            // Issue the first read one cycle early to cover the SRAM latency.
            if (is_read_reg && !is_reg_reg) begin
              mem_req_o = 1'b1;
              addr_inc  = 1'b1;
            end
          end else begin
            lat_cnt_next = lat_cnt_reg - 5'd1;
          end
        end
        RESP_READ: begin
          dq_oe_o   = 1'b1;
          rwds_oe_o = 1'b1;
          rwds_o    = 1'b1;
          dq_o      = is_reg_reg ? reg_rdata : mem_rdata_i;
          if (!is_reg_reg) begin
            mem_req_o = 1'b1;
            addr_inc  = 1'b1;
          end
        end
        RESP_WRITE: begin
          if (!is_reg_reg) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_wdata_o = dq_i;
            mem_be_o    = ~rwds_i;
            addr_inc    = 1'b1;
          end
`ifdef HYPERBUS_RESP_REGS_EN
          else if (!reg_done_reg) begin
            reg_done_next = 1'b1;
            if (reg_hit_reg) cr0_next = hyper_resp_cr0_t'(dq_i);
          end
`endif
        end
        default: state_next = RESP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= RESP_IDLE;
      cs_prev_reg  <= 1'b0;
      ca_cnt_reg   <= 2'd0;
      ca_shift_reg <= 32'h0;
      lat_cnt_reg  <= 5'd0;
      is_read_reg  <= 1'b0;
      is_reg_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cs_prev_reg  <= cs_ni;
      ca_cnt_reg   <= ca_cnt_next;
      ca_shift_reg <= ca_shift_next;
      lat_cnt_reg  <= lat_cnt_next;
      is_read_reg  <= is_read_next;
      is_reg_reg   <= is_reg_next;
    end
  end

  hyperbus_resp_addr_gen #(
    .AddrWidth(AddrWidth),
    .WrapWords(WrapWords)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (addr_load),
    .load_addr_i(load_addr),
    .linear_i   (ca.burst_type),
    .inc_i      (addr_inc),
    .addr_o     (addr_cur)
  );

  assign mem_addr_o = mem_req_o ? addr_cur : '0;

endmodule

// File: tb/tb_hyperbus_phy_responder.sv
// Directed bench for hyperbus_phy_responder with a bench-side SRAM model.
module tb_hyperbus_phy_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic [15:0] dq_in;
  logic [1:0]  rwds_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        rwds_out;
  logic        rwds_oe;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic [15:0] mem_rdata;

  logic [15:0] sram [0:65535];
  logic [15:0] req_log [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  hyperbus_phy_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cs_ni      (cs_n),
    .dq_i       (dq_in),
    .rwds_i     (rwds_in),
    .dq_o       (dq_out),
    .dq_oe_o    (dq_oe),
    .rwds_o     (rwds_out),
    .rwds_oe_o  (rwds_oe),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_be_o   (mem_be),
    .mem_rdata_i(mem_rdata)
  );

  // SRAM: always ready, one-cycle read latency, per-byte write enables.
  always @(posedge clk) begin
    if (mem_req) begin
      req_log.push_back(mem_addr);
      if (mem_we) begin
        if (mem_be[0]) sram[mem_addr][7:0] <= mem_wdata[7:0];
        if (mem_be[1]) sram[mem_addr][15:8] <= mem_wdata[15:8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select edge cycle, then the three CA words; reports {rwds_oe, rwds_o} seen on the last word.
  task automatic send_ca(input logic rw_n, input logic as, input logic linear,
                         input logic [31:0] addr, output logic [1:0] ca_rwds);
    logic [47:0] ca;
    ca = {rw_n, as, linear, addr[31:3], 13'd0, addr[2:0]};
    cs_n = 1'b0; dq_in = 16'h0; tick();
    dq_in = ca[47:32]; tick();
    dq_in = ca[31:16]; tick();
    dq_in = ca[15:0];
    #1;
    ca_rwds = {rwds_oe, rwds_out};
    @(posedge clk); #1;
    dq_in = 16'h0;
  endtask

  // Single-word read: flags any early dq_oe during the expected latency.
  task automatic read_one(input logic as, input logic [31:0] addr, input int lat,
                          output logic [15:0] data, output logic timing_ok);
    logic [1:0] ca_rwds;
    send_ca(1'b1, as, 1'b1, addr, ca_rwds);
    timing_ok = 1'b1;
    for (int i = 0; i < lat; i++) begin
      if (dq_oe) timing_ok = 1'b0;
      tick();
    end
    if (!dq_oe) timing_ok = 1'b0;
    data = dq_out;
    cs_n = 1'b1; tick();
  endtask

  function automatic logic [59:0] out_vec();
    return {dq_out, dq_oe, rwds_out, rwds_oe, mem_req, mem_we, mem_addr, mem_wdata, mem_be};
  endfunction

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; dq_in = 16'h0; rwds_in = 2'b00;
    tick(); tick();
    total_cnt++;
    if (out_vec() !== 60'h0) $display("FAIL reset_outputs: got %h expected 0", out_vec());
    else pass_cnt++;
    rst = 1'b0; tick(); tick();
    total_cnt++;
    if (out_vec() !== 60'h0) $display("FAIL idle_outputs: got %h expected 0", out_vec());
    else pass_cnt++;
  endtask

  task automatic test_linear_read();
    logic [1:0] ca_rwds;
    logic       early, saw_req;
    for (int k = 0; k < 4; k++) sram[16'h10 + k] = 16'hA000 + 16'(k);
    send_ca(1'b1, 1'b0, 1'b1, 32'h10, ca_rwds);
    total_cnt++;
    if (ca_rwds !== 2'b11) $display("FAIL ca_rwds: got %b expected 11", ca_rwds);
    else pass_cnt++;
    early = 1'b0; saw_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (dq_oe) early = 1'b1;
      if (i == 11) saw_req = mem_req && !mem_we && (mem_addr == 16'h10);
      else if (mem_req) early = 1'b1;
      tick();
    end
    total_cnt++;
    if (early !== 1'b0) $display("FAIL lin_latency: got early activity 1 expected 0");
    else pass_cnt++;
    total_cnt++;
    if (saw_req !== 1'b1) $display("FAIL lin_first_req: got %b expected 1", saw_req);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (dq_oe !== 1'b1 || dq_out !== 16'hA000 + 16'(k))
        $display("FAIL lin_data%0d: got oe=%b %h expected oe=1 %h", k, dq_oe, dq_out, 16'hA000 + 16'(k));
      else pass_cnt++;
      tick();
    end
    cs_n = 1'b1;
    #1;
    total_cnt++;
    if (out_vec() !== 60'h0) $display("FAIL cs_deassert: got %h expected 0", out_vec());
    else pass_cnt++;
    tick();
  endtask

  task automatic test_masked_write();
    logic [1:0] ca_rwds;
    logic       early;
    sram[16'h20] = 16'h0000;
    sram[16'h21] = 16'hABCD;
    send_ca(1'b0, 1'b0, 1'b1, 32'h20, ca_rwds);
    early = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem_req) early = 1'b1;
      tick();
    end
    total_cnt++;
    if (early !== 1'b0) $display("FAIL wr_latency: got early mem_req 1 expected 0");
    else pass_cnt++;
    dq_in = 16'h1111; rwds_in = 2'b00;
    #1;
    total_cnt++;
    if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b1, 16'h20, 2'b11})
      $display("FAIL wr_req: got req=%b we=%b addr=%h be=%b expected 1 1 0020 11",
               mem_req, mem_we, mem_addr, mem_be);
    else pass_cnt++;
    tick();
    dq_in = 16'h2222; rwds_in = 2'b01; tick();
    cs_n = 1'b1; dq_in = 16'h0; rwds_in = 2'b00; tick();
    total_cnt++;
    if (sram[16'h20] !== 16'h1111) $display("FAIL wr_word0: got %h expected 1111", sram[16'h20]);
    else pass_cnt++;
    total_cnt++;
    if (sram[16'h21] !== 16'h22CD) $display("FAIL wr_word1: got %h expected 22cd", sram[16'h21]);
    else pass_cnt++;
  endtask

  task automatic test_wrapped_read();
    logic [1:0]  ca_rwds;
    logic [15:0] exp_addr [4];
    logic [15:0] got;
    exp_addr = '{16'h1E, 16'h1F, 16'h10, 16'h11};
    for (int k = 0; k < 4; k++) sram[exp_addr[k]] = 16'hB000 + exp_addr[k];
    req_log.delete();
    send_ca(1'b1, 1'b0, 1'b0, 32'h1E, ca_rwds);
    for (int i = 0; i < 12; i++) tick();
    for (int k = 0; k < 4; k++) begin
      got = (req_log.size() > k) ? req_log[k] : 16'hFFFF;
      total_cnt++;
      if (got !== exp_addr[k] || dq_out !== 16'hB000 + exp_addr[k])
        $display("FAIL wrap_%0d: got addr %h data %h expected addr %h data %h",
                 k, got, dq_out, exp_addr[k], 16'hB000 + exp_addr[k]);
      else pass_cnt++;
      tick();
    end
    cs_n = 1'b1; tick();
  endtask

  task automatic test_abort();
    logic [47:0] ca;
    logic [15:0] data;
    logic        timing_ok;
    int          n_req;
    ca = {1'b1, 1'b0, 1'b1, 29'h0, 13'd0, 3'h0};
    sram[16'h40] = 16'hC040;
    req_log.delete();
    cs_n = 1'b0; tick();
    dq_in = ca[47:32]; tick();
    dq_in = ca[31:16]; tick();
    cs_n = 1'b1;
    #1;
    total_cnt++;
    if (rwds_oe !== 1'b0) $display("FAIL abort_rwds_oe: got %b expected 0", rwds_oe);
    else pass_cnt++;
    tick();
    n_req = req_log.size();
    total_cnt++;
    if (n_req !== 0) $display("FAIL abort_no_req: got %0d requests expected 0", n_req);
    else pass_cnt++;
    read_one(1'b0, 32'h40, 12, data, timing_ok);
    total_cnt++;
    if (data !== 16'hC040 || timing_ok !== 1'b1)
      $display("FAIL after_abort_read: got %h timing %b expected c040 timing 1", data, timing_ok);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] ca_rwds;
    logic       active;
    send_ca(1'b0, 1'b0, 1'b1, 32'h50, ca_rwds);
    for (int i = 0; i < 12; i++) tick();
    dq_in = 16'hD001; tick();
    dq_in = 16'hD002; tick();
    dq_in = 16'hD003; rst = 1'b1; tick();
    rst = 1'b0;
    active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_vec() !== 60'h0) active = 1'b1;
      tick();
    end
    total_cnt++;
    if (active !== 1'b0) $display("FAIL rst_quiet: got activity 1 expected 0");
    else pass_cnt++;
    cs_n = 1'b1; dq_in = 16'h0; tick();
    total_cnt++;
    if ({sram[16'h50], sram[16'h51]} !== {16'hD001, 16'hD002})
      $display("FAIL rst_pre_words: got %h %h expected d001 d002", sram[16'h50], sram[16'h51]);
    else pass_cnt++;
  endtask

  task automatic test_register();
    logic [1:0]  ca_rwds;
    logic [15:0] data;
    logic        timing_ok;
    int          n_req;
    sram[16'h800] = 16'hEEEE;
`ifdef HYPERBUS_RESP_REGS_EN
    read_one(1'b1, 32'h800, 12, data, timing_ok);
    total_cnt++;
    if (data !== 16'h8F6F || timing_ok !== 1'b1)
      $display("FAIL cr0_reset: got %h timing %b expected 8f6f timing 1", data, timing_ok);
    else pass_cnt++;
`endif
    req_log.delete();
    send_ca(1'b0, 1'b1, 1'b1, 32'h800, ca_rwds);
    dq_in = 16'h8F2F;
    #1;
    total_cnt++;
    if (mem_req !== 1'b0) $display("FAIL reg_write_no_req: got %b expected 0", mem_req);
    else pass_cnt++;
    tick();
    cs_n = 1'b1; dq_in = 16'h0; tick();
`ifdef HYPERBUS_RESP_REGS_EN
    read_one(1'b1, 32'h800, 4, data, timing_ok);
    total_cnt++;
    if (data !== 16'h8F2F || timing_ok !== 1'b1)
      $display("FAIL cr0_readback: got %h timing %b expected 8f2f timing 1", data, timing_ok);
    else pass_cnt++;
    read_one(1'b0, 32'h40, 4, data, timing_ok);
    total_cnt++;
    if (data !== 16'hC040 || timing_ok !== 1'b1)
      $display("FAIL short_lat_read: got %h timing %b expected c040 timing 1", data, timing_ok);
    else pass_cnt++;
`else
    read_one(1'b1, 32'h800, 12, data, timing_ok);
    total_cnt++;
    if (data !== 16'h0000 || timing_ok !== 1'b1)
      $display("FAIL reg_read_zero: got %h timing %b expected 0000 timing 1", data, timing_ok);
    else pass_cnt++;
    n_req = req_log.size();
    total_cnt++;
    if (n_req !== 0) $display("FAIL reg_no_sram: got %0d requests expected 0", n_req);
    else pass_cnt++;
`endif
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) sram[a] = 16'h0;
    mem_rdata = 16'h0;
    rst = 1'b1; cs_n = 1'b1; dq_in = 16'h0; rwds_in = 2'b00;
    test_reset();
    test_linear_read();
    test_masked_write();
    test_wrapped_read();
    test_abort();
    test_reset_mid_write();
    test_register();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
